// File: rtl/hero_write_deframer.sv
`default_nettype none
// ============================================================================
// Module      : hero_write_deframer
// Description : Frames hero write beats into a FWFT buffer with last markers,
//               truncating or dropping malformed/overflowing transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module hero_write_deframer #(
    parameter int HERO_WIDTH = 36,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_BEATS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            hero_cycle_type,
    input  logic [HERO_WIDTH-1:0] hero_wdat,
    input  logic                  hero_clk_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [HERO_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [15:0]           txn_count,
    output logic                  err_overflow,
    output logic                  err_protocol,
    input  logic                  err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MAX_BEATS + 1);

    localparam logic [1:0]    c_TYPE_VALID = 2'd1;
    localparam logic [1:0]    c_TYPE_DONE  = 2'd2;
    localparam logic [1:0]    c_TYPE_ILL   = 2'd3;
    localparam logic [CW-1:0] c_LAST_BEAT  = CW'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_beat_cnt;
    logic [CW-1:0]         w_beat_cnt_nxt;
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [HERO_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_last;
    logic                  r_armed;
    logic [15:0]           r_txn_count;
    logic                  r_err_ovf;
    logic                  r_err_prot;

    logic          w_empty;
    logic          w_full;
    logic          w_single;
    logic          w_pop;
    logic          w_live;
    logic          w_illegal;
    logic          w_is_done;
    logic          w_can_push;
    logic          w_push;
    logic          w_push_last;
    logic          w_set_ovf;
    logic          w_set_prot;
    logic          w_interrupt;
    logic          w_force_last;
    logic [AW-1:0] w_tail_idx;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_single   = ((r_wr_ptr - r_rd_ptr) == (AW+1)'(1));
    assign w_pop      = !w_empty && out_ready;
    assign w_is_done  = (hero_cycle_type == c_TYPE_DONE);
    // r_armed masks the bus for the first cycle after reset release
    assign w_live     = r_armed && hero_clk_en &&
                        ((hero_cycle_type == c_TYPE_VALID) || w_is_done);
    assign w_illegal  = r_armed && hero_clk_en && (hero_cycle_type == c_TYPE_ILL);
    assign w_can_push = !w_full || w_pop;
    assign w_tail_idx = r_wr_ptr[AW-1:0] - AW'(1);

    // The interrupted beat is the newest entry; it is gone once the FIFO
    // drains or if it leaves through the handshake this very cycle.
    assign w_force_last = w_interrupt && !w_empty && !(w_pop && w_single);

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_push         = 1'b0;
        w_push_last    = 1'b0;
        w_set_ovf      = 1'b0;
        w_set_prot     = 1'b0;
        w_interrupt    = 1'b0;
        case (r_state)
            ST_IDLE, ST_BUSY: begin
                if (w_illegal) begin
                    w_set_prot     = 1'b1;
                    w_interrupt    = (r_state == ST_BUSY);
                    w_state_nxt    = ST_DROP;
                    w_beat_cnt_nxt = '0;
                end else if (w_live && !w_can_push) begin
                    w_set_ovf      = 1'b1;
                    w_interrupt    = (r_state == ST_BUSY);
                    w_state_nxt    = ST_DROP;
                    w_beat_cnt_nxt = '0;
                end else if (w_live && w_is_done) begin
                    w_push         = 1'b1;
                    w_push_last    = 1'b1;
                    w_state_nxt    = ST_IDLE;
                    w_beat_cnt_nxt = '0;
                end else if (w_live) begin
                    w_push = 1'b1;
                    if (r_beat_cnt == c_LAST_BEAT) begin
                        w_push_last    = 1'b1;
                        w_set_prot     = 1'b1;
                        w_state_nxt    = ST_DROP;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_state_nxt    = ST_BUSY;
                        w_beat_cnt_nxt = r_beat_cnt + CW'(1);
                    end
                end
            end
            ST_DROP: begin
                w_set_prot = w_illegal;
                if (w_live && w_is_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_beat_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_armed     <= 1'b0;
            r_txn_count <= '0;
            r_err_ovf   <= 1'b0;
            r_err_prot  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_armed    <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (((w_push && w_push_last) || w_force_last) && (r_txn_count != 16'hFFFF)) begin
                r_txn_count <= r_txn_count + 16'd1;
            end
            if (w_set_ovf) begin
                r_err_ovf <= 1'b1;
            end else if (r_armed && err_clr) begin
                r_err_ovf <= 1'b0;
            end
            if (w_set_prot) begin
                r_err_prot <= 1'b1;
            end else if (r_armed && err_clr) begin
                r_err_prot <= 1'b0;
            end
        end
    end

    // Storage is not reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr[AW-1:0]] <= hero_wdat;
            r_mem_last[r_wr_ptr[AW-1:0]] <= w_push_last;
        end else if (w_force_last) begin
            r_mem_last[w_tail_idx] <= 1'b1;
        end
    end

    assign out_valid    = !w_empty;
    assign out_data     = w_empty ? '0 : r_mem_data[r_rd_ptr[AW-1:0]];
    assign out_last     = w_empty ? 1'b0 : r_mem_last[r_rd_ptr[AW-1:0]];
    assign txn_count    = r_txn_count;
    assign err_overflow = r_err_ovf;
    assign err_protocol = r_err_prot;

endmodule
`default_nettype wire

// File: tb/tb_hero_write_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hero_write_deframer
// Description : Self-checking bench: vector table, corner sequences, random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hero_write_deframer;

    localparam int W     = 36;
    localparam int DEPTH = 8;
    localparam int MAXB  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    ct = 2'd0;
    logic [W-1:0]  wdat = '0;
    logic          en = 1'b0;
    logic          ready = 1'b0;
    logic          clr = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [15:0]   txn_count;
    logic          err_overflow;
    logic          err_protocol;

    hero_write_deframer #(
        .HERO_WIDTH (W),
        .FIFO_DEPTH (DEPTH),
        .MAX_BEATS  (MAXB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hero_cycle_type (ct),
        .hero_wdat       (wdat),
        .hero_clk_en     (en),
        .out_valid       (out_valid),
        .out_ready       (ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .txn_count       (txn_count),
        .err_overflow    (err_overflow),
        .err_protocol    (err_protocol),
        .err_clr         (clr)
    );

    always #5 clk = ~clk;

    // Reference model: buffered beats as a queue plus transaction mode.
    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    beat_t q[$];
    int    m_mode;   // 0 between transactions, 1 inside one, 2 discarding
    int    m_nb;     // beats pushed for the open transaction
    bit    m_arm;
    int    m_txn;
    bit    m_eo;
    bit    m_ep;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mode = 0;
        m_nb   = 0;
        m_arm  = 1'b0;
        m_txn  = 0;
        m_eo   = 1'b0;
        m_ep   = 1'b0;
    endtask

    task automatic model_step();
        bit    pop, live, ill, room, so, sp, brk, push;
        beat_t nb, tmp;
        pop  = (q.size() > 0) && ready;
        live = m_arm && en && (ct == 2'd1 || ct == 2'd2);
        ill  = m_arm && en && (ct == 2'd3);
        room = (q.size() < DEPTH) || pop;
        so = 0; sp = 0; brk = 0; push = 0;
        nb.d = wdat;
        nb.l = 1'b0;
        if (pop) tmp = q.pop_front();
        if (m_mode == 2) begin
            if (ill) sp = 1;
            else if (live && ct == 2'd2) m_mode = 0;
        end else if (ill) begin
            sp = 1; brk = (m_mode == 1); m_mode = 2; m_nb = 0;
        end else if (live && !room) begin
            so = 1; brk = (m_mode == 1); m_mode = 2; m_nb = 0;
        end else if (live) begin
            push = 1;
            if (ct == 2'd2) begin
                nb.l = 1; m_mode = 0; m_nb = 0;
            end else if (m_nb + 1 == MAXB) begin
                nb.l = 1; sp = 1; m_mode = 2; m_nb = 0;
            end else begin
                m_mode = 1; m_nb++;
            end
        end
        if (brk && q.size() > 0) begin
            tmp = q[q.size()-1];
            tmp.l = 1'b1;
            q[q.size()-1] = tmp;
            if (m_txn < 65535) m_txn++;
        end
        if (push) begin
            q.push_back(nb);
            if (nb.l && m_txn < 65535) m_txn++;
        end
        if (m_arm && clr) begin
            m_eo = 0;
            m_ep = 0;
        end
        if (so) m_eo = 1;
        if (sp) m_ep = 1;
        m_arm = 1'b1;
    endtask

    task automatic compare_all();
        logic [W-1:0] ed;
        logic         el;
        if (q.size() > 0) begin
            ed = q[0].d;
            el = q[0].l;
        end else begin
            ed = '0;
            el = 1'b0;
        end
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_data", out_data, ed);
        chk("out_last", out_last, el);
        chk("txn_count", txn_count, m_txn);
        chk("err_overflow", err_overflow, m_eo);
        chk("err_protocol", err_protocol, m_ep);
    endtask

    task automatic step(input logic [1:0] t, input logic [W-1:0] d,
                        input logic e, input logic r, input logic c);
        ct    = t;
        wdat  = d;
        en    = e;
        ready = r;
        clr   = c;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ct = 2'd0; wdat = '0; en = 1'b0; ready = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]   t;
        logic [W-1:0] d;
        logic         e;
        logic         r;
        logic         ev;
        logic [W-1:0] ed;
        logic         el;
        logic [15:0]  etx;
    } vec_t;

    vec_t tv[12];

    initial begin
        logic [63:0] rr;
        int          p_done, p_rdy;
        int          sel;
        logic [1:0]  rt;

        // VALID A, VALID B, DONE C; single DONE D; gated and IDLE beats; stall.
        tv[0]  = '{2'd1, 36'h0_0000_00AA, 1'b1, 1'b1, 1'b0, 36'h0,           1'b0, 16'd0};
        tv[1]  = '{2'd1, 36'hF_0000_00A1, 1'b1, 1'b1, 1'b1, 36'hF_0000_00A1, 1'b0, 16'd0};
        tv[2]  = '{2'd1, 36'h0_0000_00B2, 1'b1, 1'b1, 1'b1, 36'h0_0000_00B2, 1'b0, 16'd0};
        tv[3]  = '{2'd2, 36'h8_1234_56C3, 1'b1, 1'b1, 1'b1, 36'h8_1234_56C3, 1'b1, 16'd1};
        tv[4]  = '{2'd0, 36'h0,           1'b1, 1'b1, 1'b0, 36'h0,           1'b0, 16'd1};
        tv[5]  = '{2'd2, 36'h0_0000_00D4, 1'b1, 1'b1, 1'b1, 36'h0_0000_00D4, 1'b1, 16'd2};
        tv[6]  = '{2'd1, 36'h0_0000_0055, 1'b0, 1'b1, 1'b0, 36'h0,           1'b0, 16'd2};
        tv[7]  = '{2'd0, 36'h0_0000_0066, 1'b1, 1'b0, 1'b0, 36'h0,           1'b0, 16'd2};
        tv[8]  = '{2'd1, 36'h0_0000_0077, 1'b1, 1'b0, 1'b1, 36'h0_0000_0077, 1'b0, 16'd2};
        tv[9]  = '{2'd2, 36'h0_0000_0088, 1'b1, 1'b0, 1'b1, 36'h0_0000_0077, 1'b0, 16'd3};
        tv[10] = '{2'd0, 36'h0,           1'b1, 1'b1, 1'b1, 36'h0_0000_0088, 1'b1, 16'd3};
        tv[11] = '{2'd0, 36'h0,           1'b1, 1'b1, 1'b0, 36'h0,           1'b0, 16'd3};

        model_reset();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tv[i].t, tv[i].d, tv[i].e, tv[i].r, 1'b0);
            chk("vec_valid", out_valid, tv[i].ev);
            chk("vec_data", out_data, tv[i].ed);
            chk("vec_last", out_last, tv[i].el);
            chk("vec_txn", txn_count, tv[i].etx);
        end

        // Overflow: 9 VALIDs into a stalled 8-deep FIFO.
        do_reset();
        step(2'd0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(2'd1, W'(100 + i), 1'b1, 1'b0, 1'b0);
        chk("ovf_flag", err_overflow, 1'b1);
        chk("ovf_txn", txn_count, 16'd1);
        step(2'd2, W'(999), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(2'd0, '0, 1'b0, 1'b1, 1'b0);
            if (k == 6) begin
                chk("ovf_tail_data", out_data, W'(107));
                chk("ovf_tail_last", out_last, 1'b1);
            end
        end
        chk("ovf_drained", out_valid, 1'b0);
        step(2'd1, W'(300), 1'b1, 1'b1, 1'b0);
        chk("ovf_fresh_a", out_data, W'(300));
        step(2'd2, W'(301), 1'b1, 1'b1, 1'b0);
        chk("ovf_fresh_b", out_last, 1'b1);
        chk("ovf_fresh_txn", txn_count, 16'd2);
        step(2'd0, '0, 1'b0, 1'b1, 1'b1);
        chk("ovf_clr", err_overflow, 1'b0);

        // Truncation at MAX_BEATS consecutive VALIDs.
        do_reset();
        step(2'd0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < MAXB; i++) step(2'd1, W'(200 + i), 1'b1, 1'b1, 1'b0);
        chk("trunc_data", out_data, W'(215));
        chk("trunc_last", out_last, 1'b1);
        chk("trunc_prot", err_protocol, 1'b1);
        chk("trunc_txn", txn_count, 16'd1);
        for (int i = 0; i < 3; i++) step(2'd1, W'(400 + i), 1'b1, 1'b1, 1'b0);
        chk("trunc_dropped", out_valid, 1'b0);
        step(2'd2, W'(410), 1'b1, 1'b1, 1'b0);
        chk("trunc_done_dropped", out_valid, 1'b0);
        step(2'd2, W'(411), 1'b1, 1'b1, 1'b1);
        chk("trunc_resume", out_data, W'(411));
        chk("trunc_clr", err_protocol, 1'b0);
        step(2'd3, '0, 1'b1, 1'b1, 1'b1);
        chk("ill_set_wins", err_protocol, 1'b1);
        step(2'd2, '0, 1'b1, 1'b1, 1'b0);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        step(2'd0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            step((i % 4 == 3) ? 2'd2 : 2'd1, W'(500 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(((DEPTH + i) % 4 == 3) ? 2'd2 : 2'd1, W'(508 + i), 1'b1, 1'b1, 1'b0);
        chk("full_no_ovf", err_overflow, 1'b0);
        chk("full_head", out_data, W'(520));
        for (int i = 0; i < DEPTH + 1; i++) step(2'd0, '0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-transaction.
        do_reset();
        step(2'd0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(2'd1, W'(600 + i), 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_txn", txn_count, 16'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2'd1, W'(700), 1'b1, 1'b1, 1'b0);
        step(2'd1, W'(701), 1'b1, 1'b1, 1'b0);
        chk("rst_first_after", out_data, W'(701));
        step(2'd2, W'(702), 1'b1, 1'b1, 1'b0);
        chk("rst_clean_txn", txn_count, 16'd1);
        step(2'd0, '0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            p_done = (blk % 2 == 0) ? 20 : 3;
            p_rdy  = 30 + 15 * blk;
            for (int c = 0; c < 500; c++) begin
                sel = $urandom_range(0, 99);
                if (sel < 4)                rt = 2'd3;
                else if (sel < 4 + p_done)  rt = 2'd2;
                else if (sel < 15 + p_done) rt = 2'd0;
                else                        rt = 2'd1;
                rr = {$urandom, $urandom};
                step(rt, rr[W-1:0], ($urandom_range(0, 7) != 0),
                     ($urandom_range(0, 99) < p_rdy), ($urandom_range(0, 49) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hero_write_deframer.md
HERO_WRITE_DEFRAMER -- requirements
Module: hero_write_deframer

Interface
REQ-001 Parameter HERO_WIDTH, default 36, data width of one hero beat.
REQ-002 Parameter FIFO_DEPTH, default 8, beat buffer entries; power of two, >=2.
REQ-003 Parameter MAX_BEATS, default 16, maximum beats per transaction, including the DONE beat.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous assert, active-low reset.
REQ-006 hero_cycle_type  in  2  beat type: 0 IDLE, 1 VALID, 2 DONE, 3 illegal.
REQ-007 hero_wdat  in  HERO_WIDTH  beat data.
REQ-008 hero_clk_en  in  1  bus qualifier; the beat is ignored when 0.
REQ-009 out_valid  out  1  a buffered beat is presented.
REQ-010 out_ready  in  1  downstream accepts the beat when out_valid && out_ready.
REQ-011 out_data  out  HERO_WIDTH  beat data.
REQ-012 out_last  out  1  the presented beat ends its transaction.
REQ-013 txn_count  out  16  count of transactions fully written into the FIFO; saturates at 16'hFFFF.
REQ-014 err_overflow  out  1  sticky flag: a beat was lost because the FIFO was full.
REQ-015 err_protocol  out  1  sticky flag: illegal type seen, or the transaction exceeded MAX_BEATS.
REQ-016 err_clr  in  1  synchronous clear of both sticky flags.

Function
REQ-017 A beat is live only when hero_clk_en=1 and hero_cycle_type is VALID or DONE; IDLE beats and beats with hero_clk_en=0 have no effect.
REQ-018 The FSM has three states: IDLE, BUSY and DROP.
REQ-019 In IDLE, a live VALID beat is pushed and the FSM moves to BUSY; a live DONE beat is pushed with last=1 as a single-beat transaction and the FSM stays in IDLE.
REQ-020 In BUSY, a VALID beat is pushed; a DONE beat is pushed with last=1 and the FSM returns to IDLE.
REQ-021 The beat counter counts pushed beats of the current transaction and resets to 0 on each DONE.
REQ-022 A VALID beat that would be beat number MAX_BEATS is pushed with last=1, sets err_protocol, and moves the FSM to DROP.
REQ-023 A live beat arriving while the FIFO is full is discarded, sets err_overflow, and moves the FSM to DROP (from IDLE or BUSY).
REQ-024 On entering DROP, the last pushed beat of the interrupted transaction, if it is still in the FIFO and not yet popped, has its last bit forced to 1; if it has already been popped, no further action is taken.
REQ-025 In DROP, all beats are discarded until a live DONE beat arrives; that DONE beat is also discarded and the FSM returns to IDLE.
REQ-026 hero_cycle_type=3 with hero_clk_en=1 sets err_protocol, is discarded, and moves the FSM to DROP from IDLE or BUSY.
REQ-027 The FIFO is first-word-fall-through: out_valid=!empty, and out_data/out_last come from the head entry.
REQ-028 A push into an empty FIFO appears on out_valid in the next cycle (1-cycle latency).
REQ-029 When the FIFO is full, a pop and a push in the same cycle are both allowed; the push is not an overflow.
REQ-030 Once asserted, out_valid/out_data/out_last hold stable until the handshake completes.
REQ-031 Read and write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full and empty are decoded from the MSB difference.
REQ-032 txn_count increments in the cycle a last=1 beat is pushed, including the forced-last case of REQ-024 and the truncation case of REQ-022.
REQ-033 When err_clr and a new error occur in the same cycle, the set wins.

Reset
REQ-034 When rst_n=0, out_valid=0, out_last=0, out_data=0, txn_count=0, err_overflow=0, err_protocol=0, the FSM is IDLE, the beat counter is 0, and both pointers are 0.
REQ-035 Reset mid-transaction discards all buffered beats; no partial transaction is emitted after reset is released.
REQ-036 Inputs are ignored during the first cycle after rst_n deasserts.

Verification
REQ-037 VALID A, VALID B, DONE C with out_ready=1 -> out shows A, B, C in order, last=1 only on C, and txn_count=1.
REQ-038 Single DONE beat D from IDLE -> one output beat D with last=1, and txn_count=1.
REQ-039 out_ready=0, 9 VALID beats with FIFO_DEPTH=8 -> the 9th beat is dropped, err_overflow=1, and the 8th buffered beat has last=1; the following DONE is discarded; a later fresh VALID/DONE pair passes intact.
REQ-040 16 consecutive VALID beats -> the 16th beat has last=1, err_protocol=1, and all beats are dropped until DONE.
REQ-041 FIFO full with simultaneous push and pop for 20 cycles -> no overflow, and data order is preserved.
REQ-042 rst_n pulsed low after 3 VALID beats -> out_valid=0 and txn_count=0; the next transaction is emitted cleanly.
